// File: rtl/uart_pkg.sv
// Shared UART constants and pointer-width derivation used by the RX and TX FIFOs.
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  // An extra wrap bit above the index bits distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver / APB read side and the receive FIFO.
interface uart_rx_fifo_if #(
  parameter int DATA_W = uart_pkg::DATA_W_DEF,
  parameter int DEPTH  = uart_pkg::DEPTH_DEF
);
  import uart_pkg::*;

  localparam int CW = ptr_w(DEPTH);

  // Handshake: w_en_rx qualifies data_in as a valid character; there is no
  // ready, so a character arriving while full is dropped and flagged in ovf_rx.
  // r_en is a read request accepted only when !e_rx; an accepted read returns
  // data_out together with a one-cycle rd_valid pulse after the sampling edge.
  logic              w_en_rx;
  logic [DATA_W-1:0] data_in;
  logic              r_en;
  logic              ovf_clr;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              f_rx;
  logic              e_rx;
  logic              af_rx;
  logic [CW-1:0]     count;
  logic              ovf_rx;

  modport master (
    output w_en_rx, data_in, r_en, ovf_clr,
    input  data_out, rd_valid, f_rx, e_rx, af_rx, count, ovf_rx
  );

  modport slave (
    input  w_en_rx, data_in, r_en, ovf_clr,
    output data_out, rd_valid, f_rx, e_rx, af_rx, count, ovf_rx
  );

endinterface

// File: rtl/uart_edge_det.sv
// Rising-edge detector: one-cycle pulse in the cycle the input first goes high.
module uart_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sig_q <= 1'b0;
    else      sig_q <= sig;
  end

  // Combinational against the registered history so the write is not delayed.
  assign rise = sig & ~sig_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with fill level, almost-full and sticky overrun.
// Optional FIFO_RX_EDGE_DET_EN: one write per rising edge of w_en_rx.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0]     w_ptr;
  logic [PW-1:0]     r_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_evt;
  logic              wr_acc;
  logic              rd_acc;
  logic              full;
  logic              empty;
  logic [PW-1:0]     level;

`ifdef FIFO_RX_EDGE_DET_EN
  uart_edge_det u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .sig  (bus.w_en_rx),
    .rise (wr_evt)
  );
`else
  assign wr_evt = bus.w_en_rx;
`endif

  assign full   = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
  assign empty  = (w_ptr == r_ptr);
  assign level  = w_ptr - r_ptr;
  assign rd_acc = bus.r_en && !empty;
  // A read in the same edge frees the slot, so a full FIFO can still accept.
  assign wr_acc = wr_evt && (!full || rd_acc);

  assign bus.f_rx  = full;
  assign bus.e_rx  = empty;
  assign bus.count = level;
  assign bus.af_rx = (32'(level) >= AF_LEVEL);

  // Storage carries no reset; validity is defined solely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr[AW-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      bus.data_out <= '0;
      bus.rd_valid <= 1'b0;
      bus.ovf_rx   <= 1'b0;
    end else begin
      bus.rd_valid <= rd_acc;
      if (wr_acc) w_ptr <= w_ptr + 1'b1;
      if (rd_acc) begin
        r_ptr        <= r_ptr + 1'b1;
        bus.data_out <= mem[r_ptr[AW-1:0]];
      end
      // Set has priority over clear so a coincident overrun is never lost.
      if (wr_evt && full && !rd_acc) bus.ovf_rx <= 1'b1;
      else if (bus.ovf_clr)          bus.ovf_rx <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF     = DEPTH - 2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  uart_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_dout;
  logic              m_rdv;
  logic              m_ovf;
  logic              m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_dout = '0;
    m_rdv  = 1'b0;
    m_ovf  = 1'b0;
    m_prev = 1'b0;
  endtask

  task automatic compare_all(input string t);
    check({t, "_count"}, 32'(bus.count), 32'(exp_q.size()));
    check({t, "_e_rx"},  32'(bus.e_rx),  32'(exp_q.size() == 0));
    check({t, "_f_rx"},  32'(bus.f_rx),  32'(exp_q.size() == DEPTH));
    check({t, "_af_rx"}, 32'(bus.af_rx), 32'(exp_q.size() >= AF));
    check({t, "_ovf"},   32'(bus.ovf_rx), 32'(m_ovf));
    check({t, "_rdv"},   32'(bus.rd_valid), 32'(m_rdv));
    check({t, "_dout"},  32'(bus.data_out), 32'(m_dout));
  endtask

  // driver: one clock cycle of stimulus, then model update and comparison
  task automatic cycle(input string t, input logic w, input logic [DATA_W-1:0] d,
                       input logic r, input logic c);
    logic evt, full, empty, rd, wr;
    @(negedge clk);
    bus.w_en_rx = w;
    bus.data_in = d;
    bus.r_en    = r;
    bus.ovf_clr = c;
`ifdef FIFO_RX_EDGE_DET_EN
    evt = w && !m_prev;
`else
    evt = w;
`endif
    m_prev = w;
    full   = (exp_q.size() == DEPTH);
    empty  = (exp_q.size() == 0);
    rd     = r && !empty;
    wr     = evt && (!full || rd);
    @(posedge clk);
    #1;
    if (rd) m_dout = exp_q.pop_front();
    m_rdv = rd;
    if (wr) exp_q.push_back(d);
    if (evt && full && !rd) m_ovf = 1'b1;
    else if (c)             m_ovf = 1'b0;
    compare_all(t);
  endtask

  task automatic push(input string t, input logic [DATA_W-1:0] d);
    cycle(t, 1'b1, d, 1'b0, 1'b0);
    cycle(t, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic pop(input string t);
    cycle(t, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    bus.w_en_rx = 1'b0;
    bus.data_in = '0;
    bus.r_en    = 1'b0;
    bus.ovf_clr = 1'b0;
    rst         = 1'b1;
    #2;
    apply_reset();

    // three writes then three reads
    push("t1w", 8'h11);
    push("t1w", 8'h22);
    push("t1w", 8'h33);
    check("t1_count3", 32'(bus.count), 32'd3);
    pop("t1r");
    check("t1_d0", 32'(bus.data_out), 32'h11);
    pop("t1r");
    check("t1_d1", 32'(bus.data_out), 32'h22);
    pop("t1r");
    check("t1_d2", 32'(bus.data_out), 32'h33);
    pop("t1r_empty");
    check("t1_hold", 32'(bus.data_out), 32'h33);

    // fill, overrun, drain, clear
    for (int i = 0; i < DEPTH; i++) push("t2w", 8'(i));
    push("t2ovf", 8'hAA);
    check("t2_ovf_set", 32'(bus.ovf_rx), 32'd1);
    cycle("t2ovf_clr_same", 1'b1, 8'hAB, 1'b0, 1'b1);
    cycle("t2idle", 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      pop("t2r");
      check("t2_order", 32'(bus.data_out), 32'(i));
    end
    cycle("t2clr", 1'b0, '0, 1'b0, 1'b1);
    check("t2_ovf_clr", 32'(bus.ovf_rx), 32'd0);

    // full with simultaneous read and write
    for (int i = 0; i < DEPTH; i++) push("t3w", 8'(8'h80 + i));
    cycle("t3rw", 1'b1, 8'h55, 1'b1, 1'b0);
    check("t3_count", 32'(bus.count), 32'(DEPTH));
    check("t3_oldest", 32'(bus.data_out), 32'h80);
    for (int i = 0; i < DEPTH; i++) pop("t3r");
    check("t3_last", 32'(bus.data_out), 32'h55);

    // write/read pairs across pointer wrap
    for (int i = 0; i < 20; i++) begin
      push("t4w", 8'($urandom_range(0, 255)));
      pop("t4r");
    end

    // held write strobe
    for (int i = 0; i < 5; i++) cycle("t5hold", 1'b1, 8'h3C, 1'b0, 1'b0);
`ifdef FIFO_RX_EDGE_DET_EN
    check("t5_count", 32'(bus.count), 32'd1);
`else
    check("t5_count", 32'(bus.count), 32'd5);
`endif
    cycle("t5idle", 1'b0, '0, 1'b0, 1'b0);
    while (exp_q.size() != 0) pop("t5r");

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle("rnd", 1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5));

    // asynchronous reset between edges with four entries held
    cycle("t6idle", 1'b0, '0, 1'b1, 1'b1);
    while (exp_q.size() != 0) pop("t6drain");
    for (int i = 0; i < 4; i++) push("t6w", 8'(8'hC0 + i));
    check("t6_count4", 32'(bus.count), 32'd4);
    #2;
    apply_reset();
    check("t6_e_rx", 32'(bus.e_rx), 32'd1);
    push("t6post", 8'h5A);
    pop("t6post_r");
    check("t6_post", 32'(bus.data_out), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
